// File: rtl/optical_flow_pkg.sv
// Shared types and constants for the optical-flow weighting stages.
package optical_flow_pkg;

    typedef logic signed [31:0] sample_t;

    localparam int GW_ACC_W = 38;
    typedef logic signed [GW_ACC_W-1:0] acc_t;

    localparam int GW_X_W0 = 1;
    localparam int GW_X_W1 = 6;
    localparam int GW_X_W2 = 15;
    localparam int GW_X_W3 = 20;
    localparam int GW_X_W4 = 15;
    localparam int GW_X_W5 = 6;
    localparam int GW_X_W6 = 1;

    localparam int GW_SHIFT = 6;

    typedef enum logic [2:0] {
        GW_IDLE,
        GW_FILL,
        GW_RUN,
        GW_FLUSH,
        GW_DONE
    } gw_state_t;

    function automatic acc_t gw_tap(sample_t s, int w);
        return acc_t'(s) * acc_t'(w);
    endfunction

endpackage

// File: rtl/gradient_weight_x_window.sv
// 7-tap horizontal window; the sum already includes the sample being shifted in
// so the producing cycle can load its output directly.
module gradient_weight_x_window
    import optical_flow_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    shift,
    input  logic    clear,
    input  sample_t din,
    output acc_t    sum
);

    sample_t win  [7];
    sample_t view [7];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            view[i] = win[i+1];
        end
        view[6] = din;
    end

    assign sum = gw_tap(view[0], GW_X_W0)
               + gw_tap(view[1], GW_X_W1)
               + gw_tap(view[2], GW_X_W2)
               + gw_tap(view[3], GW_X_W3)
               + gw_tap(view[4], GW_X_W4)
               + gw_tap(view[5], GW_X_W5)
               + gw_tap(view[6], GW_X_W6);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                win[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < 7; i++) begin
                win[i] <= '0;
            end
        end else if (shift) begin
            for (int i = 0; i < 7; i++) begin
                win[i] <= view[i];
            end
        end
    end

endmodule

// File: rtl/gradient_weight_x_1.sv
// Horizontal 7-tap binomial weighting of a raster sample stream,
// zero-padded at row edges, one output per input.
module gradient_weight_x_1
    import optical_flow_pkg::*;
#(
    parameter int IMG_WIDTH  = 1024,
    parameter int IMG_HEIGHT = 436
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] Input_1_V_V,
    input  logic        Input_1_V_V_ap_vld,
    output logic        Input_1_V_V_ap_ack,
    output logic [31:0] Output_1_V_V,
    output logic        Output_1_V_V_ap_vld,
    input  logic        Output_1_V_V_ap_ack
);

    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);

    gw_state_t state, state_n;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    flush;

    logic    room, take, fstep, load;
    logic    last_col, last_row, last_flush;
    sample_t din;
    acc_t    sum;

    assign room       = !Output_1_V_V_ap_vld || Output_1_V_V_ap_ack;
    assign last_col   = col == CW'(IMG_WIDTH - 1);
    assign last_row   = row == RW'(IMG_HEIGHT - 1);
    assign last_flush = flush == 2'd2;

    assign Input_1_V_V_ap_ack = (state == GW_FILL)
                             || (state == GW_RUN && room);
    assign take  = Input_1_V_V_ap_vld && Input_1_V_V_ap_ack;
    assign fstep = (state == GW_FLUSH) && room;
    assign load  = (state == GW_RUN && take) || fstep;
    assign din   = take ? sample_t'(Input_1_V_V) : '0;

    assign ap_idle  = state == GW_IDLE;
    assign ap_ready = state == GW_RUN && take && last_col && last_row;
    assign ap_done  = state == GW_DONE && room;

    gradient_weight_x_window u_window (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .shift (take || fstep),
        .clear (fstep && last_flush),
        .din   (din),
        .sum   (sum)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= GW_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            GW_IDLE: begin
                if (ap_start) state_n = GW_FILL;
            end
            GW_FILL: begin
                if (take && col == CW'(2)) state_n = GW_RUN;
            end
            GW_RUN: begin
                if (take && last_col) state_n = GW_FLUSH;
            end
            GW_FLUSH: begin
                if (fstep && last_flush) begin
                    state_n = last_row ? GW_DONE : GW_FILL;
                end
            end
            GW_DONE: begin
                if (room) state_n = ap_start ? GW_FILL : GW_IDLE;
            end
            default: state_n = GW_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            col   <= '0;
            row   <= '0;
            flush <= '0;
        end else begin
            if (take) begin
                col <= last_col ? '0 : col + CW'(1);
            end
            if (fstep) begin
                flush <= last_flush ? 2'd0 : flush + 2'd1;
                if (last_flush) begin
                    row <= last_row ? '0 : row + RW'(1);
                end
            end
        end
    end

    // Single-entry output register; load wins over drain so 1 sample/cycle holds.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            Output_1_V_V        <= '0;
            Output_1_V_V_ap_vld <= 1'b0;
        end else if (load) begin
            Output_1_V_V        <= 32'(sum >>> GW_SHIFT);
            Output_1_V_V_ap_vld <= 1'b1;
        end else if (Output_1_V_V_ap_vld && Output_1_V_V_ap_ack) begin
            Output_1_V_V_ap_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gradient_weight_x_1.sv
// Scoreboard bench for gradient_weight_x_1 with W=8, H=2.
module tb_gradient_weight_x_1;

    localparam int W = 8;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ap_start = 1'b1;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_ack;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_ack = 1'b1;

    gradient_weight_x_1 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .ap_clk              (clk),
        .ap_rst              (rst),
        .ap_start            (ap_start),
        .ap_done             (ap_done),
        .ap_idle             (ap_idle),
        .ap_ready            (ap_ready),
        .Input_1_V_V         (in_data),
        .Input_1_V_V_ap_vld  (in_vld),
        .Input_1_V_V_ap_ack  (in_ack),
        .Output_1_V_V        (out_data),
        .Output_1_V_V_ap_vld (out_vld),
        .Output_1_V_V_ap_ack (out_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          last;
    } in_t;

    in_t         in_q [$];
    logic [31:0] exp_q [$];

    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;
    int n_rdy = 0;
    int n_done = 0;
    bit mon_off = 1'b0;

    logic [31:0] e_imp [8] = '{32'd1, 32'd6, 32'd15, 32'd20,
                               32'd15, 32'd6, 32'd1, 32'd0};
    logic [31:0] e_con [8] = '{32'hA800, 32'hE400, 32'hFC00, 32'h10000,
                               32'h10000, 32'hFC00, 32'hE400, 32'hA800};
    logic [31:0] e_neg [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h0};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Driver: presents the head of in_q, pops it when the DUT acks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (in_q.size() > 0) begin
                in_vld  = 1'b1;
                in_data = in_q[0].d;
                @(negedge clk);
                if (in_ack && !rst) begin
                    if (!mon_off) chk("ap_ready", {31'd0, ap_ready},
                                      {31'd0, in_q[0].last});
                    void'(in_q.pop_front());
                end
            end else begin
                in_vld = 1'b0;
            end
        end
    end

    // Monitor: compares every accepted output against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_off && !rst) begin
                if (out_vld && out_ack) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %h, required none",
                                 out_data);
                    end else begin
                        chk("out", out_data, exp_q.pop_front());
                    end
                end
                if (ap_ready) n_rdy++;
                if (ap_done) begin
                    n_done++;
                    chk("done_last", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic push_row(int kind, bit last_row);
        logic [31:0] d, e;
        for (int c = 0; c < W; c++) begin
            case (kind)
                1:       begin d = 32'h10000; e = e_con[c]; end
                2:       begin d = (c == 3) ? 32'h40 : 32'h0; e = e_imp[c]; end
                3:       begin d = (c == 3) ? 32'hFFFFFFFF : 32'h0; e = e_neg[c]; end
                4:       begin d = (c == 3) ? 32'h1 : 32'h0; e = 32'h0; end
                default: begin d = 32'h0; e = 32'h0; end
            endcase
            in_q.push_back('{d: d, last: last_row && c == W - 1});
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(string nm);
        int t = 0;
        while ((exp_q.size() > 0 || in_q.size() > 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending, required 0",
                     nm, exp_q.size());
        end
    endtask

    task automatic run_frame(string nm, int k0, int k1);
        int br = n_rdy;
        int bd = n_done;
        push_row(k0, 1'b0);
        push_row(k1, 1'b1);
        wait_drain(nm);
        repeat (3) @(negedge clk);
        chk({nm, "_ready_cnt"}, 32'(n_rdy - br), 32'd1);
        chk({nm, "_done_cnt"}, 32'(n_done - bd), 32'd1);
    endtask

    task automatic chk_reset(string nm);
        chk({nm, "_in_ack"}, {31'd0, in_ack}, 32'd0);
        chk({nm, "_out_vld"}, {31'd0, out_vld}, 32'd0);
        chk({nm, "_out_data"}, out_data, 32'd0);
        chk({nm, "_done"}, {31'd0, ap_done}, 32'd0);
        chk({nm, "_ready"}, {31'd0, ap_ready}, 32'd0);
        chk({nm, "_idle"}, {31'd0, ap_idle}, 32'd1);
    endtask

    task automatic backpressure;
        logic [31:0] hold;
        int b = n_out;
        int t = 0;
        while (n_out < b + 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reach", {31'd0, t < 200}, 32'd1);
        @(posedge clk);
        #1 out_ack = 1'b0;
        @(negedge clk);
        hold = out_data;
        chk("bp_vld", {31'd0, out_vld}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_stable", out_data, hold);
            chk("bp_in_ack", {31'd0, in_ack}, 32'd0);
        end
        @(posedge clk);
        #1 out_ack = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        @(posedge clk);
        #1 rst = 1'b0;

        run_frame("imp_con", 2, 1);
        run_frame("con_zero", 1, 0);
        run_frame("neg_one", 3, 4);

        fork
            run_frame("bp", 1, 1);
            backpressure();
        join

        mon_off = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_q.push_back('{d: 32'h10000, last: 1'b0});
        end
        wait_drain("pre_rst");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset("rst_mid");
        @(posedge clk);
        #1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        mon_off = 1'b0;

        run_frame("post_rst", 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gradient_weight_x_1.md
# gradient_weight_x_1

Horizontal 7-tap binomial weighting stage of the optical-flow pipeline. It sits directly downstream of `gradient_weight_y_1` and consumes that stage's vertically weighted 32-bit sample stream in raster order. It applies a horizontal filter with zero-padded row edges and emits one weighted sample per input sample. It is wrapped in its own leaf and uses the same HLS-style `ap_vld`/`ap_ack` stream ports.

## Interface
Parameters:
- `IMG_WIDTH`, 1024: samples per row; must be ≥ 4.
- `IMG_HEIGHT`, 436: rows per frame; must be ≥ 1.

Ports:
- `ap_clk` in 1: single clock.
- `ap_rst` in 1: asynchronous, active-high reset.
- `ap_start` in 1: frame start request; the leaf ties it to 1.
- `ap_done` out 1: one-cycle pulse when the last output of a frame is accepted.
- `ap_idle` out 1: high while in IDLE.
- `ap_ready` out 1: one-cycle pulse in the cycle the frame's last input is consumed.
- `Input_1_V_V` in 32: input sample, signed Q16.16.
- `Input_1_V_V_ap_vld` in 1: input data valid.
- `Input_1_V_V_ap_ack` out 1: block consumes the input this cycle.
- `Output_1_V_V` out 32: weighted sample, signed Q16.16.
- `Output_1_V_V_ap_vld` out 1: output data valid.
- `Output_1_V_V_ap_ack` in 1: downstream accepts the output this cycle.

## Operation
- Weights: w = {1, 6, 15, 20, 15, 6, 1}, which sum to 64.
- Output for column c: y[c] = (Σk w[k]·x[c−3+k]) >>> 6.
  - Taps with column < 0 or ≥ IMG_WIDTH read as 0.
  - Accumulate in 38-bit signed; the arithmetic shift floors toward −∞.
  - The result always fits in 32 bits, so there is no saturation.
- 7-entry window shift register.
  - Cleared to zero at each row start.
  - Shifts in the sample on every consumed input and shifts in 0 on every flush step.
- State machine:
  - IDLE: `ap_idle`=1. Go to FILL when `ap_start`=1.
  - FILL: consume columns 0..2, produce no output. After column 2, go to RUN.
  - RUN: consume columns 3..IMG_WIDTH−1; each consumption loads output y[col−3]. After the last column, go to FLUSH.
  - FLUSH: 3 steps, each shifting in 0 and loading y[W−3..W−1]. No input is consumed. Then:
    - if the row is not the last, clear the window, increment the row, go to FILL;
    - otherwise go to DONE.
  - DONE: wait for the output register to empty, pulse `ap_done`, go to IDLE. With `ap_start` held high, the next frame begins in FILL directly.
- Counters: `col` (0..W−1), `row` (0..H−1), `flush` (0..2). All wrap to 0 at row and frame end.

## Timing
- Reset values: `Input_1_V_V_ap_ack`=0, `Output_1_V_V_ap_vld`=0, `Output_1_V_V`=0, `ap_done`=0, `ap_ready`=0, `ap_idle`=1. State is IDLE, counters are 0, window is zero.
- Reset asserted mid-frame discards all data and returns the block to IDLE asynchronously. No partial output survives.
- Input transfer occurs when `ap_vld` && `ap_ack`.
  - `ap_ack` = (FILL) or (RUN and the output register is empty or being accepted this cycle).
  - `ap_ack` does not depend on `ap_vld`.
- Output register is one entry.
  - `ap_vld` rises the cycle after the producing input or flush step.
  - Data is held stable until `ap_ack`=1.
  - Load and drain in the same cycle are allowed, giving a throughput of 1 sample/cycle.
- FLUSH advances only when the output register is empty or draining that cycle.
- Latency: input column c+3 consumed at cycle t puts y[c] on the output at t+1. The last three columns of a row appear within 3 cycles after the row's last input, given no backpressure.

## Structure
- Shared package `optical_flow_pkg` holds:
  - the `sample_t` typedef (signed 32-bit Q16.16);
  - the weight constants `GW_X_W0..W6`;
  - the shift constant `GW_SHIFT`=6;
  - the accumulator width 38.
- Sub-module `gradient_weight_x_window`: 7-entry shift register with `shift`, `din`, `clear` inputs and a combinational 38-bit weighted sum output.
- Top level holds the state machine, counters, output register and handshake.

## Test plan
- Impulse, W=8, H=1: input 0x00000040 at column 3, zeros elsewhere -> outputs 1, 6, 15, 20, 15, 6, 1, 0.
- Constant, W=8, H=1: all inputs 0x00010000 -> outputs 0xA800, 0xE400, 0xFC00, 0x10000, 0x10000, 0xFC00, 0xE400, 0xA800; `ap_ready` pulses on input 8; `ap_done` pulses after output 8 is accepted.
- Floor rounding, W=8: 0xFFFFFFFF at column 3 -> outputs 0xFFFFFFFF ×7 then 0; 0x00000001 at column 3 -> all outputs 0.
- Row isolation, W=8, H=2: row 0 all 0x00010000, row 1 all 0 -> row 1 outputs all 0; 16 outputs total.
- Backpressure: hold `Output_1_V_V_ap_ack` low for 5 cycles mid-row -> `Output_1_V_V` stable, `Input_1_V_V_ap_ack` low while the register is full, no loss or duplication, the constant-row sequence is unchanged.
- Reset mid-frame after 5 inputs -> all outputs at reset values within the same cycle; a following full frame matches the constant-row sequence.
